// File: rtl/pe_serializer.sv
// Gathers one DATA_DEPTH-lane vector and streams the lanes selected by a mask,
// one per beat, tagged with their lane index and a last flag.
module pe_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 33,
  parameter int SEL_WIDTH  = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data [DATA_DEPTH-1:0],
  input  logic [DATA_DEPTH-1:0] in_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [SEL_WIDTH-1:0]  out_sel,
  output logic                  out_last,
  output logic                  busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and data/sel/last hold while valid && !ready.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]            state_q;
  logic [SEL_WIDTH-1:0]  idx_q;
  logic [DATA_DEPTH-1:0] mask_q;
  logic [DATA_WIDTH-1:0] buf_q [DATA_DEPTH-1:0];

  logic [SEL_WIDTH-1:0]  first_idx;
  logic                  first_found;
  logic [SEL_WIDTH-1:0]  next_idx;
  logic                  next_found;

  // Lowest set bit of the offered mask; the search never leaves 0..DATA_DEPTH-1.
  always_comb begin
    first_idx   = '0;
    first_found = 1'b0;
    for (int i = DATA_DEPTH - 1; i >= 0; i--) begin
      if (in_mask[i]) begin
        first_idx   = SEL_WIDTH'(i);
        first_found = 1'b1;
      end
    end
  end

  // Next set bit strictly above the current lane; absence of one marks the last beat.
  always_comb begin
    next_idx   = '0;
    next_found = 1'b0;
    for (int i = DATA_DEPTH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(idx_q))) begin
        next_idx   = SEL_WIDTH'(i);
        next_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      for (int i = 0; i < DATA_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mask_q <= in_mask;
            for (int i = 0; i < DATA_DEPTH; i++) begin
              buf_q[i] <= in_data[i];
            end
            // An all-zero mask consumes the vector without producing beats.
            if (first_found) begin
              state_q <= SEND;
              idx_q   <= first_idx;
            end
          end
        end
        SEND: begin
          if (out_ready) begin
            if (next_found) begin
              idx_q <= next_idx;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q == SEND);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = busy;
  assign out_data  = busy ? buf_q[idx_q] : '0;
  assign out_sel   = busy ? idx_q : '0;
  assign out_last  = busy && !next_found;

endmodule

// File: tb/tb_pe_serializer.sv
// Self-checking bench for pe_serializer: directed scenarios plus randomized
// vectors, all compared against a queue of expected beats built from the mask.
module tb_pe_serializer;

  localparam int DW = 8;
  localparam int DD = 33;
  localparam int SW = $clog2(DD);
  localparam int EW = 1 + SW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data [DD-1:0];
  logic [DD-1:0] in_mask = '0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_sel;
  logic          out_last;
  logic          busy;

  // Expected beats packed as {last, sel, data}
  logic [EW-1:0] exp_q[$];

  int  n_checks = 0;
  int  n_fails  = 0;
  int  cyc      = 0;
  int  beats    = 0;
  int  captures = 0;
  int  cap_cyc  = 0;
  int  last_xfer_cyc = 0;
  bit  b2b_chk  = 1'b0;
  int  rdy_mode = 0;   // 0: always ready, 1: random, 2: manual
  logic ready_man = 1'b0;
  logic rnd_rdy   = 1'b1;

  assign out_ready = (rdy_mode == 2) ? ready_man : rnd_rdy;

  pe_serializer #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .out_last(out_last),
    .busy(busy)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: the beats of a vector are its set mask bits in ascending
  // order, the highest one carrying last.
  task automatic model_capture(input logic [DD-1:0] m);
    int hi;
    hi = -1;
    for (int i = 0; i < DD; i++) if (m[i]) hi = i;
    for (int i = 0; i < DD; i++) begin
      if (m[i]) exp_q.push_back({(i == hi), SW'(i), in_data[i]});
    end
  endtask

  // Monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      check_val("in_ready", 64'(in_ready), 64'(exp_q.size() == 0));
      check_val("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check_val("busy", 64'(busy), 64'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        check_val("out_beat", 64'({out_last, out_sel, out_data}), 64'(exp_q[0]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          beats++;
          last_xfer_cyc = cyc;
        end
      end else if (!out_valid) begin
        check_val("idle_zero", 64'({out_last, out_sel, out_data}), 64'(0));
      end
      if (in_valid && in_ready) begin
        if (b2b_chk) check_val("b2b_gap", 64'(cyc - last_xfer_cyc), 64'(1));
        model_capture(in_mask);
        captures++;
        cap_cyc = cyc;
      end
    end
  end

  // Random ready generator
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_rdy = (rdy_mode == 0) ? 1'b1 : (($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end
  end

  // Offer one vector and return just after the capture edge
  task automatic offer(input logic [DD-1:0] m, input bit pat, input bit hold);
    bit done;
    done = 1'b0;
    for (int k = 0; k < DD; k++) in_data[k] = pat ? DW'(k + 16) : DW'($urandom);
    in_mask  = m;
    in_valid = 1'b1;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check_val("offer_timeout", 64'(0), 64'(1));
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check_val("drain_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int b0, c0;
    logic [DW-1:0] lane3;
    logic [DD-1:0] m;
    bit found;
    for (int k = 0; k < DD; k++) in_data[k] = '0;

    // Reset state
    idle_cycles(3);
    @(negedge clk);
    check_val("rst_out_valid", 64'(out_valid), 64'(0));
    check_val("rst_busy", 64'(busy), 64'(0));
    check_val("rst_outs", 64'({out_last, out_sel, out_data}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    // 1: full mask, patterned data, always ready
    rdy_mode = 0;
    b0 = beats;
    offer({DD{1'b1}}, 1'b1, 1'b0);
    drain();
    check_val("full_beats", 64'(beats - b0), 64'(DD));
    check_val("full_span", 64'(last_xfer_cyc - cap_cyc), 64'(DD));

    // 2: sparse mask with wide gaps
    b0 = beats;
    offer(33'h1_0000_0021, 1'b0, 1'b0);
    drain();
    check_val("sparse_beats", 64'(beats - b0), 64'(3));
    check_val("sparse_span", 64'(last_xfer_cyc - cap_cyc), 64'(3));

    // 3: zero mask is consumed silently
    c0 = captures;
    b0 = beats;
    offer('0, 1'b0, 1'b0);
    idle_cycles(3);
    check_val("zero_accept", 64'(captures - c0), 64'(1));
    check_val("zero_beats", 64'(beats - b0), 64'(0));

    // 4: backpressure on the first of two beats
    rdy_mode  = 2;
    ready_man = 1'b0;
    offer(33'h0_0000_0018, 1'b0, 1'b0);
    lane3 = in_data[3];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("stall_sel", 64'(out_sel), 64'(3));
      check_val("stall_data", 64'(out_data), 64'(lane3));
      check_val("stall_last", 64'(out_last), 64'(0));
      @(posedge clk);
      #1;
    end
    ready_man = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("after_stall_sel", 64'(out_sel), 64'(4));
    check_val("after_stall_last", 64'(out_last), 64'(1));
    drain();
    rdy_mode = 0;

    // 5: back-to-back vectors with in_valid held
    b0 = beats;
    offer(33'h0_0000_00F1, 1'b0, 1'b1);
    b2b_chk = 1'b1;
    offer(33'h1_0000_0003, 1'b0, 1'b0);
    b2b_chk = 1'b0;
    drain();
    check_val("b2b_beats", 64'(beats - b0), 64'(8));

    // 6: reset while beat sel=2 of a full vector is on the bus
    offer({DD{1'b1}}, 1'b0, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (out_valid && out_sel == 2) found = 1'b1;
    end
    check_val("rst_mid_found", 64'(found), 64'(1));
    #1;
    rst = 1'b1;
    #1;
    check_val("rst_mid_valid", 64'(out_valid), 64'(0));
    check_val("rst_mid_busy", 64'(busy), 64'(0));
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    b0 = beats;
    idle_cycles(40);
    check_val("rst_mid_ready", 64'(in_ready), 64'(1));
    check_val("rst_mid_beats", 64'(beats - b0), 64'(0));

    // Randomized vectors with random backpressure
    rdy_mode = 1;
    for (int v = 0; v < 150; v++) begin
      case ($urandom_range(0, 4))
        0:       m = {1'($urandom), 32'($urandom)};
        1:       m = {1'($urandom), 32'($urandom & $urandom & $urandom)};
        2:       m = DD'(1) << $urandom_range(0, DD - 1);
        3:       m = '0;
        default: m = {DD{1'b1}};
      endcase
      offer(m, 1'b0, ($urandom_range(0, 1) == 1));
    end
    in_valid = 1'b0;
    drain();
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
